// File: rtl/fp_pkg.sv
// ---------------------------------------------------------------------------
// fp_pkg
// Shared definitions for the floating-point adder requester:
//   - single-precision field widths
//   - default watchdog limit and counter width
//   - requester FSM state type
//   - small helper used by the FSM and by the result slot
// ---------------------------------------------------------------------------
package fp_pkg;

   localparam int FP_W       = 32;
   localparam int FP_EXP_W   = 8;
   localparam int FP_MAN_W   = 23;
   localparam int FP_TIMEOUT = 1023;
   localparam int FP_CW      = 10;

   typedef enum logic [2:0] {
      S_IDLE,
      S_ISSUE,
      S_WAIT_LOW,
      S_WAIT_HIGH,
      S_CAPTURE,
      S_ERR
   } req_state_t;

   // A single-entry slot can take new data when it is empty or is being
   // drained in the same cycle.
   function automatic logic slot_free(input logic valid, input logic ready);
      return !valid || ready;
   endfunction

endpackage

// File: rtl/fp_add_requester_if.sv
// ---------------------------------------------------------------------------
// fp_add_requester_if
// Bundles every handshake/data signal of fp_add_requester.
//   Operand stream : in_valid, in_ready, in_a, in_b
//   Adder control  : start, done, op_a, op_b, res_in
//   Result stream  : out_valid, out_ready, out_result
//   Error          : timeout_err, clr_err
// master = requester view, slave = environment (source/adder/consumer) view.
// ---------------------------------------------------------------------------
interface fp_add_requester_if
   import fp_pkg::*;
#(
   parameter int W = FP_W
);

   logic         in_valid;
   logic         in_ready;
   logic [W-1:0] in_a;
   logic [W-1:0] in_b;
   logic         start;
   logic         done;
   logic [W-1:0] op_a;
   logic [W-1:0] op_b;
   logic [W-1:0] res_in;
   logic         out_valid;
   logic         out_ready;
   logic [W-1:0] out_result;
   logic         timeout_err;
   logic         clr_err;

   modport master (
      input  in_valid, in_a, in_b, done, res_in, out_ready, clr_err,
      output in_ready, start, op_a, op_b, out_valid, out_result, timeout_err
   );

   modport slave (
      output in_valid, in_a, in_b, done, res_in, out_ready, clr_err,
      input  in_ready, start, op_a, op_b, out_valid, out_result, timeout_err
   );

endinterface

// File: rtl/fp_result_slot.sv
// ---------------------------------------------------------------------------
// fp_result_slot
// Single-entry valid/ready output register. A load in the same cycle as a
// consume keeps valid high with the new data.
// Ports:
//   clk_i, rst_ni : clock, asynchronous active-low reset
//   load_i        : capture data_i this cycle (caller only loads when free_o)
//   data_i        : data to capture
//   ready_i       : consumer accepts the current entry
//   valid_o       : entry valid
//   data_o        : entry data, stable while valid_o & !ready_i
//   free_o        : slot can take a load this cycle
// ---------------------------------------------------------------------------
module fp_result_slot
   import fp_pkg::*;
#(
   parameter int W = FP_W
) (
   input  logic         clk_i,
   input  logic         rst_ni,
   input  logic         load_i,
   input  logic [W-1:0] data_i,
   input  logic         ready_i,
   output logic         valid_o,
   output logic [W-1:0] data_o,
   output logic         free_o
);

   logic         valid_q, valid_d;
   logic [W-1:0] data_q,  data_d;

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         valid_q <= 1'b0;
         data_q  <= '0;
      end else begin
         valid_q <= valid_d;
         data_q  <= data_d;
      end
   end

   always_comb begin
      valid_d = valid_q;
      data_d  = data_q;
      if (valid_q && ready_i) begin
         valid_d = 1'b0;
      end
      // Load wins over consume so a back-to-back result is not lost.
      if (load_i) begin
         valid_d = 1'b1;
         data_d  = data_i;
      end
   end

   assign valid_o = valid_q;
   assign data_o  = data_q;
   assign free_o  = slot_free(valid_q, ready_i);

endmodule

// File: rtl/fp_add_requester.sv
// ---------------------------------------------------------------------------
// fp_add_requester
// Initiator for the fp adder start/done handshake. Accepts an operand pair,
// pulses start for one cycle, holds the operands, waits for done to fall and
// rise again, then hands the result to a single-entry output slot. A
// watchdog raises a sticky timeout_err if done does not come back in time.
// Ports:
//   CLK : clock, rising edge
//   rst : asynchronous active-low reset
//   bus : fp_add_requester_if.master (operand stream, adder control,
//         result stream, error flag/clear)
// CW must satisfy 2**CW > TIMEOUT.
// ---------------------------------------------------------------------------
module fp_add_requester
   import fp_pkg::*;
#(
   parameter int W       = FP_W,
   parameter int TIMEOUT = FP_TIMEOUT,
   parameter int CW      = FP_CW
) (
   input  logic                CLK,
   input  logic                rst,
   fp_add_requester_if.master  bus
);

   localparam logic [CW-1:0] TO_CNT = CW'(TIMEOUT);

   req_state_t   state_q, state_d;
   logic [CW-1:0] wd_q, wd_d;
   logic         err_q, err_d;
   logic         alive_q;
   logic [W-1:0] op_a_q, op_a_d;
   logic [W-1:0] op_b_q, op_b_d;

   logic         in_ready_c;
   logic         start_c;
   logic         load_c;
   logic         slot_free_c;
   logic         slot_valid;
   logic [W-1:0] slot_data;

   always_ff @(posedge CLK or negedge rst) begin
      if (!rst) begin
         state_q <= S_IDLE;
         wd_q    <= '0;
         err_q   <= 1'b0;
         alive_q <= 1'b0;
         op_a_q  <= '0;
         op_b_q  <= '0;
      end else begin
         state_q <= state_d;
         wd_q    <= wd_d;
         err_q   <= err_d;
         // Keeps in_ready low until the first clock after reset release.
         alive_q <= 1'b1;
         op_a_q  <= op_a_d;
         op_b_q  <= op_b_d;
      end
   end

   always_comb begin
      state_d    = state_q;
      wd_d       = wd_q;
      err_d      = err_q;
      op_a_d     = op_a_q;
      op_b_d     = op_b_q;
      in_ready_c = 1'b0;
      start_c    = 1'b0;
      load_c     = 1'b0;

      case (state_q)
         S_IDLE: begin
            // done=0 here means the adder is still busy elsewhere.
            in_ready_c = alive_q && bus.done && !err_q;
            if (in_ready_c && bus.in_valid) begin
               op_a_d  = bus.in_a;
               op_b_d  = bus.in_b;
               state_d = S_ISSUE;
            end
         end
         S_ISSUE: begin
            // The adder only advances once start drops, so one cycle only.
            start_c = 1'b1;
            wd_d    = '0;
            state_d = S_WAIT_LOW;
         end
         S_WAIT_LOW: begin
            wd_d = wd_q + 1'b1;
            if (wd_q == TO_CNT) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end else if (!bus.done) begin
               state_d = S_WAIT_HIGH;
            end
         end
         S_WAIT_HIGH: begin
            wd_d = wd_q + 1'b1;
            // done checked first: a rise on the limit cycle is a success.
            if (bus.done) begin
               if (slot_free_c) begin
                  load_c  = 1'b1;
                  state_d = S_IDLE;
               end else begin
                  state_d = S_CAPTURE;
               end
            end else if (wd_q == TO_CNT) begin
               err_d   = 1'b1;
               state_d = S_ERR;
            end
         end
         S_CAPTURE: begin
            // Adder is idle, so res_in stays valid while we wait.
            if (slot_free_c) begin
               load_c  = 1'b1;
               state_d = S_IDLE;
            end
         end
         S_ERR: begin
            if (bus.clr_err) begin
               err_d   = 1'b0;
               state_d = S_IDLE;
            end
         end
         default: begin
            state_d = S_IDLE;
         end
      endcase
   end

   fp_result_slot #(
      .W (W)
   ) u_slot (
      .clk_i   (CLK),
      .rst_ni  (rst),
      .load_i  (load_c),
      .data_i  (bus.res_in),
      .ready_i (bus.out_ready),
      .valid_o (slot_valid),
      .data_o  (slot_data),
      .free_o  (slot_free_c)
   );

   assign bus.in_ready    = in_ready_c;
   assign bus.start       = start_c;
   assign bus.op_a        = op_a_q;
   assign bus.op_b        = op_b_q;
   assign bus.out_valid   = slot_valid;
   assign bus.out_result  = slot_data;
   assign bus.timeout_err = err_q;

endmodule

// File: tb/tb_fp_add_requester.sv
module tb_fp_add_requester;

   localparam int W   = 32;
   localparam int TO  = 20;
   localparam int CWT = 5;

   logic clk = 1'b0;
   logic rst = 1'b0;
   always #5 clk = ~clk;

   fp_add_requester_if #(.W(W)) bus();

   fp_add_requester #(
      .W       (W),
      .TIMEOUT (TO),
      .CW      (CWT)
   ) dut (
      .CLK (clk),
      .rst (rst),
      .bus (bus)
   );

   int n_chk  = 0;
   int n_fail = 0;

   // Adder model controls / state
   int          m_lat       = 6;
   bit          m_stuck     = 1'b0;
   bit          m_force_low = 1'b0;
   bit          m_busy      = 1'b0;
   int          m_cnt       = 0;
   logic [31:0] m_res       = '0;

   int start_run = 0;
   int max_start_run = 0;
   int start_cnt = 0;

   typedef struct {
      logic [31:0] a;
      logic [31:0] b;
      int          lat;
      logic [31:0] res;
   } vec_t;

   vec_t vecs [4];

   // Positive normal single-precision add, truncating.
   function automatic logic [31:0] sp_add(input logic [31:0] a_in, input logic [31:0] b_in);
      logic [31:0] a, b;
      logic [7:0]  ea, eb;
      logic [24:0] ma, mb, s;
      a = a_in;
      b = b_in;
      if (a[30:23] < b[30:23]) begin
         a = b_in;
         b = a_in;
      end
      ea = a[30:23];
      eb = b[30:23];
      ma = {2'b01, a[22:0]};
      mb = {2'b01, b[22:0]} >> (ea - eb);
      s  = ma + mb;
      if (s[24]) begin
         s  = s >> 1;
         ea = ea + 8'd1;
      end
      return {1'b0, ea, s[22:0]};
   endfunction

   // Behavioural adder: done drops the cycle after start, stays low m_lat cycles.
   always @(posedge clk) begin
      #1;
      if (!rst) begin
         m_busy = 1'b0;
         m_cnt  = 0;
         bus.done   = 1'b1;
         bus.res_in = '0;
      end else if (m_busy) begin
         m_cnt++;
         if (m_cnt == 1) begin
            bus.done   = 1'b0;
            bus.res_in = 32'hDEADBEEF;
         end
         if (m_cnt == m_lat + 1) begin
            bus.done   = 1'b1;
            bus.res_in = m_res;
            m_busy     = 1'b0;
         end
      end else begin
         bus.done = !m_force_low;
         if (bus.start === 1'b1 && !m_stuck && !m_force_low) begin
            m_busy = 1'b1;
            m_cnt  = 0;
            m_res  = sp_add(bus.op_a, bus.op_b);
         end
      end
   end

   always @(negedge clk) begin
      if (bus.start === 1'b1) begin
         start_run++;
         start_cnt++;
      end else begin
         start_run = 0;
      end
      if (start_run > max_start_run) max_start_run = start_run;
   end

   task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
      n_chk++;
      if (act !== exp) begin
         n_fail++;
         $display("FAIL %s: got %h expected %h", nm, act, exp);
      end
   endtask

   // Called at a negedge; returns at the negedge of the ISSUE cycle.
   task automatic issue(input logic [31:0] a, input logic [31:0] b, input int lat);
      bit acc;
      acc = 1'b0;
      m_lat = lat;
      bus.in_a = a;
      bus.in_b = b;
      bus.in_valid = 1'b1;
      for (int k = 0; k < 100 && !acc; k++) begin
         acc = (bus.in_ready === 1'b1);
         @(negedge clk);
      end
      bus.in_valid = 1'b0;
      chk("accept", {31'd0, acc}, 32'd1);
   endtask

   task automatic wait_valid(output int cyc);
      cyc = 0;
      while (bus.out_valid !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("out_valid_seen", {31'd0, bus.out_valid}, 32'd1);
   endtask

   task automatic wait_err(output int cyc);
      cyc = 0;
      while (bus.timeout_err !== 1'b1 && cyc < 200) begin
         @(negedge clk);
         cyc++;
      end
      chk("timeout_err_seen", {31'd0, bus.timeout_err}, 32'd1);
   endtask

   task automatic chk_reset_outputs(input string tag);
      chk({tag, "_in_ready"},   {31'd0, bus.in_ready},    32'd0);
      chk({tag, "_start"},      {31'd0, bus.start},       32'd0);
      chk({tag, "_op_a"},       bus.op_a,                 32'd0);
      chk({tag, "_op_b"},       bus.op_b,                 32'd0);
      chk({tag, "_out_valid"},  {31'd0, bus.out_valid},   32'd0);
      chk({tag, "_out_result"}, bus.out_result,           32'd0);
      chk({tag, "_timeout"},    {31'd0, bus.timeout_err}, 32'd0);
   endtask

   initial begin
      #200000;
      $display("FAIL global_timeout: simulation did not finish, got no end expected end");
      $fatal(1, "global timeout");
   end

   initial begin
      int cyc;
      int sc;

      vecs[0] = '{32'h3F800000, 32'h40000000, 6,  32'h40400000}; // 1+2=3
      vecs[1] = '{32'h3FC00000, 32'h3E800000, 3,  32'h3FE00000}; // 1.5+0.25
      vecs[2] = '{32'h40400000, 32'h40400000, 1,  32'h40C00000}; // 3+3=6
      vecs[3] = '{32'h41200000, 32'h3F800000, 10, 32'h41300000}; // 10+1=11

      bus.in_valid  = 1'b0;
      bus.in_a      = '0;
      bus.in_b      = '0;
      bus.out_ready = 1'b0;
      bus.clr_err   = 1'b0;
      rst = 1'b0;

      // Reset state
      @(negedge clk);
      chk_reset_outputs("reset");
      rst = 1'b1;
      #1;
      chk("in_ready_before_clk", {31'd0, bus.in_ready}, 32'd0);
      @(negedge clk);
      chk("in_ready_after_clk", {31'd0, bus.in_ready}, 32'd1);

      // Table-driven basic operations
      bus.out_ready = 1'b1;
      for (int i = 0; i < 4; i++) begin
         issue(vecs[i].a, vecs[i].b, vecs[i].lat);
         chk("start_pulse", {31'd0, bus.start}, 32'd1);
         wait_valid(cyc);
         chk("result", bus.out_result, vecs[i].res);
         chk("latency", cyc, vecs[i].lat + 2);
         chk("in_ready_after_cap", {31'd0, bus.in_ready}, 32'd1);
         chk("op_a_held", bus.op_a, vecs[i].a);
         chk("op_b_held", bus.op_b, vecs[i].b);
         @(negedge clk);
         chk("out_valid_drained", {31'd0, bus.out_valid}, 32'd0);
      end

      // Backpressure: second result parks in CAPTURE
      bus.out_ready = 1'b0;
      issue(32'h3F800000, 32'h3F800000, 2);
      wait_valid(cyc);
      chk("bp_first", bus.out_result, 32'h40000000);
      issue(32'h40000000, 32'h40000000, 2);
      repeat (8) @(negedge clk);
      chk("bp_held_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_held_data", bus.out_result, 32'h40000000);
      chk("bp_capture_in_ready", {31'd0, bus.in_ready}, 32'd0);
      bus.out_ready = 1'b1;
      @(negedge clk);
      chk("bp_swap_valid", {31'd0, bus.out_valid}, 32'd1);
      chk("bp_swap_data", bus.out_result, 32'h40800000);
      chk("bp_swap_in_ready", {31'd0, bus.in_ready}, 32'd1);
      @(negedge clk);
      chk("bp_drained", {31'd0, bus.out_valid}, 32'd0);

      // Stuck adder: done never falls
      m_stuck = 1'b1;
      issue(32'h3F800000, 32'h40000000, 6);
      repeat (TO + 1) @(negedge clk);
      chk("stuck_not_yet", {31'd0, bus.timeout_err}, 32'd0);
      @(negedge clk);
      chk("stuck_err", {31'd0, bus.timeout_err}, 32'd1);
      chk("stuck_in_ready", {31'd0, bus.in_ready}, 32'd0);
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
      chk("stuck_cleared", {31'd0, bus.timeout_err}, 32'd0);
      chk("stuck_in_ready_back", {31'd0, bus.in_ready}, 32'd1);
      m_stuck = 1'b0;

      // Boundary: done rises exactly when the watchdog hits TIMEOUT
      issue(32'h3F800000, 32'h40000000, TO);
      wait_valid(cyc);
      chk("edge_ok_result", bus.out_result, 32'h40400000);
      chk("edge_ok_latency", cyc, TO + 2);
      chk("edge_ok_no_err", {31'd0, bus.timeout_err}, 32'd0);
      @(negedge clk);

      // One cycle late -> error, late result is not captured
      issue(32'h3F800000, 32'h40000000, TO + 1);
      wait_err(cyc);
      chk("edge_late_cycles", cyc, TO + 2);
      repeat (3) @(negedge clk);
      chk("edge_late_no_result", {31'd0, bus.out_valid}, 32'd0);
      bus.clr_err = 1'b1;
      @(negedge clk);
      bus.clr_err = 1'b0;
      chk("edge_late_recover", {31'd0, bus.in_ready}, 32'd1);

      // Reset mid-operation with a result waiting in the slot
      bus.out_ready = 1'b0;
      issue(32'h3F800000, 32'h40000000, 2);
      wait_valid(cyc);
      issue(32'h3F800000, 32'h3F800000, 10);
      repeat (4) @(negedge clk);
      #2;
      rst = 1'b0;
      #1;
      chk_reset_outputs("midrst");
      @(negedge clk);
      rst = 1'b1;
      bus.out_ready = 1'b1;
      @(negedge clk);
      issue(32'h3FC00000, 32'h3E800000, 3);
      wait_valid(cyc);
      chk("midrst_recover", bus.out_result, 32'h3FE00000);
      @(negedge clk);

      // Adder busy while requester idles
      m_force_low = 1'b1;
      repeat (2) @(negedge clk);
      sc = start_cnt;
      bus.in_a = 32'h41200000;
      bus.in_b = 32'h3F800000;
      bus.in_valid = 1'b1;
      repeat (4) @(negedge clk);
      chk("busy_in_ready", {31'd0, bus.in_ready}, 32'd0);
      chk("busy_no_start", start_cnt, sc);
      m_force_low = 1'b0;
      issue(32'h41200000, 32'h3F800000, 4);
      wait_valid(cyc);
      chk("busy_result", bus.out_result, 32'h41300000);
      chk("busy_one_start", start_cnt, sc + 1);
      @(negedge clk);

      chk("start_width", max_start_run, 1);

      $display("End of test - %0d assertions evaluated, %0d failures", n_chk, n_fail);
      $finish;
   end

endmodule
